// File: rtl/lsu_controller.sv
// Load/store sequencer: req/gnt/rvalid bus handshake, lane steering, load extension, bus timeout.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_controller #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic [2:0]        i_Funct3,
    input  logic [DATA_W-1:0] i_Addr,
    input  logic [DATA_W-1:0] i_WData,
    output logic              o_Stall,
    output logic              o_Done,
    output logic [DATA_W-1:0] o_RData,
    output logic              o_BusErr,
    output logic              o_MisalignErr,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_b;
    logic              r_is_h;
    logic              r_uns;
    logic [1:0]        r_off;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_buserr;
    logic              r_misalign;

    logic              w_req;
    logic              w_is_b;
    logic              w_is_h;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misalign;
    logic              w_timeout;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_load;

    assign w_req  = i_MemRead | i_MemWrite;
    assign w_is_b = (i_Funct3[1:0] == 2'b00);
    assign w_is_h = (i_Funct3[1:0] == 2'b01);

    // Offset is truncated to the access size, so H ignores a[0] and W ignores a[1:0].
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = i_WData;
        if (w_is_b) begin
            w_off   = i_Addr[1:0];
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{i_WData[7:0]}};
        end else if (w_is_h) begin
            w_off   = {i_Addr[1], 1'b0};
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{i_WData[15:0]}};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_h && i_Addr[0]) || (!w_is_b && !w_is_h && (i_Addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    assign w_lane = i_mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_lane;
        if (r_is_b)
            w_load = r_uns ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
        else if (r_is_h)
            w_load = r_uns ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_b      <= 1'b0;
            r_is_h      <= 1'b0;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_buserr    <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_b      <= w_is_b;
                        r_is_h      <= w_is_h;
                        r_uns       <= i_Funct3[2];
                        r_off       <= w_off;
                        r_mem_we    <= i_MemWrite;
                        r_mem_addr  <= {i_Addr[DATA_W-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_buserr    <= 1'b0;
                        r_cnt       <= '0;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end else begin
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_misalign <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        r_state   <= S_WAIT;
                        r_mem_req <= 1'b0;
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_buserr  <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (!r_mem_we)
                            r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_buserr <= 1'b1;
                        r_rdata  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Error flags are only meaningful alongside the done pulse.
                    r_state    <= S_IDLE;
                    r_buserr   <= 1'b0;
                    r_misalign <= 1'b0;
                end
            endcase
        end
    end

    assign o_Stall     = ((r_state == S_IDLE) && w_req) || (r_state == S_REQ) || (r_state == S_WAIT);
    assign o_Done      = r_done;
    assign o_RData     = r_rdata;
    assign o_BusErr    = r_buserr;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_MisalignErr = r_misalign;
`else
    assign o_MisalignErr = 1'b0;
`endif

endmodule
